// File: rtl/adbg_jsp_wb_host.sv
// Wishbone host for a 16550-style JTAG serial port: initialises the UART,
// then polls LSR and moves single bytes between the port and tx/rx handshakes.
module adbg_jsp_wb_host #(
  parameter logic [31:0] BASE_ADDR     = 32'h9000_0000,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        int_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned      CNT_W       = 8;
  localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [31:0]      LSR_ADDR    = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_INIT_LCR, S_INIT_FCR, S_INIT_IER, S_IDLE, S_POLL_LSR, S_READ_RBR, S_WRITE_THR
  } state_t;

  state_t           r_state;
  state_t           w_issue_state;
  logic [CNT_W-1:0] r_poll_cnt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_tx_empty;
  logic             r_rx_full;
  logic [7:0]       r_tx_byte;
  logic [7:0]       r_rx_byte;
  logic             w_timeout;
  logic             w_term;
  logic             w_fail;
  logic             w_can_poll;
  logic [7:0]       w_lsr;
  logic [31:0]      w_iss_adr;
  logic [31:0]      w_iss_dat;
  logic [3:0]       w_iss_sel;
  logic             w_iss_we;
  logic             w_unused;

  assign w_timeout     = wb_stb_o && (r_tmo_cnt == TMO_LAST);
  assign w_fail        = wb_cyc_o && (wb_err_i || w_timeout);
  assign w_term        = wb_cyc_o && (wb_ack_i || wb_err_i || w_timeout);
  assign w_lsr         = wb_dat_i[23:16];
  assign w_can_poll    = !r_tx_empty || !r_rx_full;
  // IDLE launches the LSR read on the same edge it decides to poll
  assign w_issue_state = (r_state == S_IDLE) ? S_POLL_LSR : r_state;
  assign w_unused      = ^wb_dat_i[15:0];

  assign busy_o     = wb_cyc_o;
  assign tx_ready_o = r_tx_empty;
  assign rx_valid_o = r_rx_full;
  assign rx_data_o  = r_rx_byte;
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;

  // Address, data and lane select for the cycle a state issues
  always_comb begin
    w_iss_adr = BASE_ADDR;
    w_iss_dat = 32'h0;
    w_iss_sel = 4'b0000;
    w_iss_we  = 1'b0;
    case (w_issue_state)
      S_INIT_LCR:  begin w_iss_we = 1'b1; w_iss_sel = 4'b0001; w_iss_dat = 32'h0000_0003; end
      S_INIT_FCR:  begin w_iss_we = 1'b1; w_iss_sel = 4'b0010; w_iss_dat = 32'h0000_0600; end
      S_INIT_IER:  begin w_iss_we = 1'b1; w_iss_sel = 4'b0100; end
      S_POLL_LSR:  begin w_iss_adr = LSR_ADDR; w_iss_sel = 4'b0100; end
      S_READ_RBR:  w_iss_sel = 4'b1000;
      S_WRITE_THR: begin w_iss_we = 1'b1; w_iss_sel = 4'b1000; w_iss_dat = {r_tx_byte, 24'h0}; end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= S_INIT_LCR;
      r_poll_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_tx_empty <= 1'b1;
      r_rx_full  <= 1'b0;
      r_tx_byte  <= 8'h0;
      r_rx_byte  <= 8'h0;
      wb_adr_o   <= 32'h0;
      wb_dat_o   <= 32'h0;
      wb_sel_o   <= 4'b0000;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (tx_valid_i && r_tx_empty) begin
        r_tx_byte  <= tx_data_i;
        r_tx_empty <= 1'b0;
      end
      if (r_rx_full && rx_ready_i) r_rx_full <= 1'b0;

      if (!wb_stb_o || w_term) r_tmo_cnt <= '0;
      else                     r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);

      if (r_state == S_IDLE) begin
        if (r_poll_cnt != '0) r_poll_cnt <= r_poll_cnt - CNT_W'(1);
        if ((r_poll_cnt == '0 || int_i) && w_can_poll) begin
          r_state  <= S_POLL_LSR;
          wb_adr_o <= w_iss_adr;
          wb_dat_o <= w_iss_dat;
          wb_sel_o <= w_iss_sel;
          wb_we_o  <= w_iss_we;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
        end
      end else if (!wb_cyc_o) begin
        wb_adr_o <= w_iss_adr;
        wb_dat_o <= w_iss_dat;
        wb_sel_o <= w_iss_sel;
        wb_we_o  <= w_iss_we;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end else if (w_term) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        if (w_fail) err_o <= 1'b1;
        case (r_state)
          S_INIT_LCR: r_state <= S_INIT_FCR;
          S_INIT_FCR: r_state <= S_INIT_IER;
          S_INIT_IER: begin
            r_state    <= S_IDLE;
            r_poll_cnt <= '0;
          end
          S_POLL_LSR: begin
            if (!w_fail && w_lsr[0] && !r_rx_full) begin
              r_state <= S_READ_RBR;
            end else if (!w_fail && w_lsr[5] && !r_tx_empty) begin
              r_state <= S_WRITE_THR;
            end else begin
              r_state    <= S_IDLE;
              r_poll_cnt <= POLL_RELOAD;
            end
          end
          S_READ_RBR, S_WRITE_THR: begin
            r_state    <= S_IDLE;
            r_poll_cnt <= w_fail ? POLL_RELOAD : '0;
            if (!w_fail && r_state == S_READ_RBR) begin
              r_rx_byte <= wb_dat_i[31:24];
              r_rx_full <= 1'b1;
            end
            if (!w_fail && r_state == S_WRITE_THR) r_tx_empty <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adbg_jsp_wb_host.sv
// Self-checking bench for adbg_jsp_wb_host: a scoreboard of expected bus
// cycles checked at cycle start, plus per-scenario checks of handshakes/timing.
module tb_adbg_jsp_wb_host;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int unsigned POLL = 10;
  localparam int unsigned TMO  = 8;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        int_i = 1'b0;
  logic [7:0]  tx_data_i = 8'h0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        busy_o, err_o;

  txn_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc_cnt = 0;
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  bit         slv_ack_en = 1'b1;
  logic       m_prev = 1'b0;

  adbg_jsp_wb_host #(.BASE_ADDR(BASE), .POLL_INTERVAL(POLL), .ACK_TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .int_i(int_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave: registered one-cycle ack, read data picked by address
  assign wb_dat_i = (wb_adr_o == BASE + 32'd4) ? {8'h00, lsr_val, 16'h0000} : {rbr_val, 24'h0};
  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && slv_ack_en) wb_ack_i <= 1'b1;
    else                                                   wb_ack_i <= 1'b0;
  end

  // Scoreboard: each new bus cycle is compared against the next expected one
  always @(negedge clk) begin
    if (wb_cyc_o && !m_prev && exp_q.size() > 0) begin
      txn_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (e.we !== wb_we_o || e.adr !== wb_adr_o || e.sel !== wb_sel_o ||
          (e.we && e.dat !== wb_dat_o)) begin
        n_err++;
        $display("FAIL bus_txn: got we=%0b adr=%h sel=%b dat=%h, expected we=%0b adr=%h sel=%b dat=%h",
                 wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, e.we, e.adr, e.sel, e.dat);
      end
    end
    m_prev = wb_cyc_o;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    txn_t t;
    t.we = we; t.adr = adr; t.sel = sel; t.dat = dat;
    exp_q.push_back(t);
  endtask

  task automatic push_init();
    push(1'b1, BASE, 4'b0001, 32'h0000_0003);
    push(1'b1, BASE, 4'b0010, 32'h0000_0600);
    push(1'b1, BASE, 4'b0100, 32'h0000_0000);
    push(1'b0, BASE + 32'd4, 4'b0100, 32'h0);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    fork
      begin @(negedge clk); tx_valid_i = 1'b0; end
    join_none
  endtask

  task automatic wait_edge(input logic lvl, output int t, output bit ok);
    logic p;
    p = wb_cyc_o; ok = 1'b0; t = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb_cyc_o === lvl && p !== lvl) begin ok = 1'b1; t = cyc_cnt; break; end
      p = wb_cyc_o;
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!wb_cyc_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok, ok_all;
    int t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o} !== 4'b0000) begin
      n_err++; $display("FAIL rst_ctl: got %b expected 0000", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o});
    end
    n_vec++;
    if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0) begin
      n_err++; $display("FAIL rst_bus: got adr=%h dat=%h sel=%b expected zeros", wb_adr_o, wb_dat_o, wb_sel_o);
    end
    n_vec++;
    if (rx_valid_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++; $display("FAIL rst_flags: got rx_valid=%b err=%b expected 0 0", rx_valid_o, err_o);
    end
    n_vec++;
    if (wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) begin
      n_err++; $display("FAIL cti_bte: got %b %b expected 000 00", wb_cti_o, wb_bte_o);
    end
    push_init();
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (tx_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready_o);
    end
    wait_drain(ok_all);
    wait_edge(1'b0, t, ok);
    ok_all &= ok;
    n_vec++;
    if (!ok_all || err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL init_seq: done=%b err=%b busy=%b expected 1 0 0", ok_all, err_o, busy_o);
    end
  endtask

  task automatic test_rx();
    bit ok, ok_all, rose;
    int t;
    wait_quiet(ok_all);
    lsr_val = 8'h01; rbr_val = 8'h41;
    push(1'b0, BASE + 32'd4, 4'b0100, 32'h0);
    push(1'b0, BASE, 4'b1000, 32'h0);
    wait_drain(ok); ok_all &= ok;
    wait_edge(1'b0, t, ok); ok_all &= ok;
    @(negedge clk);
    n_vec++;
    if (!ok_all || rx_valid_o !== 1'b1 || rx_data_o !== 8'h41) begin
      n_err++; $display("FAIL rx_byte: done=%b valid=%b data=%h expected 1 1 41", ok_all, rx_valid_o, rx_data_o);
    end
    rose = 1'b0;
    repeat (3 * POLL) begin
      @(negedge clk);
      if (wb_cyc_o) rose = 1'b1;
    end
    n_vec++;
    if (rose !== 1'b0) begin
      n_err++; $display("FAIL rx_full_no_poll: bus activity=%b expected 0", rose);
    end
    lsr_val = 8'h00;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    n_vec++;
    if (rx_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rx_drain: got valid=%b expected 0", rx_valid_o);
    end
  endtask

  task automatic test_tx();
    bit ok, ok_all;
    int t;
    wait_quiet(ok_all);
    lsr_val = 8'h60;
    push(1'b0, BASE + 32'd4, 4'b0100, 32'h0);
    push(1'b1, BASE, 4'b1000, 32'h5A00_0000);
    load_tx(8'h5A);
    @(negedge clk);
    n_vec++;
    if (tx_ready_o !== 1'b0) begin
      n_err++; $display("FAIL tx_load: got ready=%b expected 0", tx_ready_o);
    end
    wait_drain(ok); ok_all &= ok;
    wait_edge(1'b0, t, ok); ok_all &= ok;
    n_vec++;
    if (!ok_all || tx_ready_o !== 1'b1) begin
      n_err++; $display("FAIL tx_done: done=%b ready=%b expected 1 1", ok_all, tx_ready_o);
    end
    lsr_val = 8'h00;
  endtask

  task automatic test_rx_priority();
    bit ok, ok_all;
    int t;
    wait_quiet(ok_all);
    lsr_val = 8'h61; rbr_val = 8'hC3;
    push(1'b0, BASE + 32'd4, 4'b0100, 32'h0);
    push(1'b0, BASE, 4'b1000, 32'h0);
    push(1'b0, BASE + 32'd4, 4'b0100, 32'h0);
    push(1'b1, BASE, 4'b1000, 32'hA700_0000);
    load_tx(8'hA7);
    wait_drain(ok); ok_all &= ok;
    wait_edge(1'b0, t, ok); ok_all &= ok;
    n_vec++;
    if (!ok_all || rx_valid_o !== 1'b1 || rx_data_o !== 8'hC3 || tx_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rx_then_tx: done=%b rx_valid=%b rx_data=%h tx_ready=%b expected 1 1 c3 1",
                        ok_all, rx_valid_o, rx_data_o, tx_ready_o);
    end
    lsr_val = 8'h00;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok, ok_all;
    int ts, te;
    wait_quiet(ok_all);
    slv_ack_en = 1'b0;
    lsr_val = 8'h60;
    push(1'b0, BASE + 32'd4, 4'b0100, 32'h0);
    push(1'b0, BASE + 32'd4, 4'b0100, 32'h0);
    push(1'b1, BASE, 4'b1000, 32'h3C00_0000);
    load_tx(8'h3C);
    wait_edge(1'b1, ts, ok); ok_all &= ok;
    wait_edge(1'b0, te, ok); ok_all &= ok;
    n_vec++;
    if (!ok_all || te - ts != int'(TMO)) begin
      n_err++; $display("FAIL timeout_len: done=%b stb cycles=%0d expected %0d", ok_all, te - ts, TMO);
    end
    n_vec++;
    if (err_o !== 1'b1 || tx_ready_o !== 1'b0) begin
      n_err++; $display("FAIL timeout_err: got err=%b tx_ready=%b expected 1 0", err_o, tx_ready_o);
    end
    slv_ack_en = 1'b1;
    wait_drain(ok); ok_all = ok;
    wait_edge(1'b0, te, ok); ok_all &= ok;
    n_vec++;
    if (!ok_all || tx_ready_o !== 1'b1 || err_o !== 1'b1) begin
      n_err++; $display("FAIL tx_retry: done=%b tx_ready=%b err=%b expected 1 1 1", ok_all, tx_ready_o, err_o);
    end
    lsr_val = 8'h00;
  endtask

  task automatic test_poll_interval();
    bit ok, ok_all;
    int ts, te, tc;
    wait_edge(1'b0, te, ok_all);
    wait_edge(1'b1, ts, ok); ok_all &= ok;
    n_vec++;
    if (!ok_all || ts - te != int'(POLL)) begin
      n_err++; $display("FAIL poll_gap: done=%b gap=%0d expected %0d", ok_all, ts - te, POLL);
    end
    wait_edge(1'b0, te, ok_all);
    int_i = 1'b1;
    tc = cyc_cnt;
    wait_edge(1'b1, ts, ok); ok_all &= ok;
    int_i = 1'b0;
    n_vec++;
    if (!ok_all || ts - tc != 1) begin
      n_err++; $display("FAIL int_poll: done=%b gap=%0d expected 1", ok_all, ts - tc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok_all;
    wait_quiet(ok_all);
    slv_ack_en = 1'b0;
    lsr_val = 8'h00;
    load_tx(8'h11);
    @(negedge clk);
    n_vec++;
    if (tx_ready_o !== 1'b0) begin
      n_err++; $display("FAIL mid_tx_load: got ready=%b expected 0", tx_ready_o);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (wb_cyc_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    ok_all &= ok;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (!ok_all || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: started=%b cyc=%b stb=%b busy=%b err=%b expected 1 0 0 0 0",
                        ok_all, wb_cyc_o, wb_stb_o, busy_o, err_o);
    end
    slv_ack_en = 1'b1;
    push_init();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (tx_ready_o !== 1'b1 || rx_valid_o !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_hold: tx_ready=%b rx_valid=%b expected 1 0", tx_ready_o, rx_valid_o);
    end
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL reinit: pending=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_rx_priority();
    test_timeout();
    test_poll_interval();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adbg_jsp_wb_host.md
ADBG_JSP_WB_HOST -- requirements
Module: adbg_jsp_wb_host

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h9000_0000: word address of the JSP 16550-style register block.
REQ-002 SHALL have parameter POLL_INTERVAL, default 16: idle cycles between LSR polls when no work is found; legal range 1..255.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles a bus cycle waits for ack/err; legal range 1..255.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
 wb_clk_i  in  1  clock
 wb_rst_ni  in  1  async active-low reset
 wb_adr_o  out  32  WB address
 wb_dat_o  out  32  WB write data
 wb_dat_i  in  32  WB read data
 wb_cyc_o, wb_stb_o, wb_we_o  out  1  WB cycle, strobe and write enable
 wb_sel_o  out  4  byte lanes
 wb_ack_i, wb_err_i  in  1  WB acknowledge and error
 wb_cti_o  out  3  always 3'b000
 wb_bte_o  out  2  always 2'b00
 int_i  in  1  JSP interrupt; forces an immediate poll
 tx_data_i  in  8  byte to send
 tx_valid_i / tx_ready_o  in/out  1  tx handshake
 rx_data_o  out  8  received byte
 rx_valid_o / rx_ready_i  out/in  1  rx handshake
 busy_o  out  1  WB cycle in progress
 err_o  out  1  sticky bus error or timeout

Function
REQ-006 Register map: offset 0 lanes [31:24] RBR/THR (sel 1000), [23:16] IER (sel 0100), [15:8] FCR (sel 0010), [7:0] LCR (sel 0001); offset 4 lane [23:16] LSR (sel 0100); LSR bit0 = RX data ready, LSR bit5 = THR not full.
REQ-007 All bus cycles SHALL be classic single cycles: adr/dat/sel/we/cyc/stb stable from issue until ack, err or timeout; cyc and stb deasserted in the cycle after termination.
REQ-008 FSM states: INIT_LCR, INIT_FCR, INIT_IER, IDLE, POLL_LSR, READ_RBR, WRITE_THR.
REQ-009 After reset the module SHALL issue, in order: LCR write 0x03 (DLAB=0) to BASE_ADDR, FCR write dat_o[15:8]=0x06 (clear both FIFOs), IER write 0x00; then enter IDLE with the poll counter at 0.
REQ-010 tx_ready_o SHALL be 1 exactly when the one-byte tx holding register is empty; a tx_valid_i&tx_ready_o cycle loads it.
REQ-011 rx_valid_o SHALL be 1 while the one-byte rx holding register is full; a rx_valid_o&rx_ready_i cycle empties it.
REQ-012 In IDLE the poll counter decrements each cycle; POLL_LSR is entered when (counter==0 or int_i) and (tx holding full or rx holding empty).
REQ-013 On LSR ack: if LSR[0] and rx empty -> READ_RBR; else if LSR[5] and tx full -> WRITE_THR; else IDLE with counter reloaded to POLL_INTERVAL-1.
REQ-014 READ_RBR ack SHALL load wb_dat_i[31:24] into rx holding; WRITE_THR SHALL drive dat_o={tx byte,24'h0}, and ack SHALL empty tx holding; both return to IDLE with counter 0.
REQ-015 RX SHALL take priority over TX when both are actionable from one LSR value.
REQ-016 Timeout: a 8-bit counter SHALL count cycles with stb asserted; reaching ACK_TIMEOUT terminates the cycle like wb_err_i.
REQ-017 On err/timeout: set err_o, discard read data, keep tx holding (retry), go to IDLE with counter reloaded (INIT states advance to next INIT state).
REQ-018 busy_o SHALL equal wb_cyc_o.
REQ-019 wb_ack_i/wb_err_i while cyc_o=0 SHALL be ignored; ack and err together SHALL be treated as err.

Reset
REQ-020 Reset SHALL asynchronously force: cyc/stb/we=0, adr/dat/sel=0, tx_ready_o=1 after reset release, rx_valid_o=0, err_o=0, busy_o=0, state INIT_LCR; a mid-cycle reset drops cyc/stb immediately and loses holding bytes.
REQ-021 err_o SHALL be cleared only by reset.

Verification
REQ-022 Reset release, slave acks in 1 cycle -> writes seen: adr BASE sel 0001 dat[7:0]=03, sel 0010 dat[15:8]=06, sel 0100 dat[23:16]=00; then LSR read at BASE+4.
REQ-023 LSR=0x01, RBR=0x41 -> rx_valid_o=1, rx_data_o=0x41; with rx_ready_i=0 no further RBR read is issued.
REQ-024 tx byte 0x5A, LSR=0x60 -> write at BASE sel 1000 dat=32'h5A00_0000; tx_ready_o returns to 1 after ack.
REQ-025 LSR=0x61 with rx empty and tx full -> RBR read precedes THR write.
REQ-026 Slave never acks, ACK_TIMEOUT=8 -> stb drops after 8 cycles, err_o=1, tx byte retried after next poll.
REQ-027 LSR=0x00, no int_i -> next LSR read exactly POLL_INTERVAL cycles after return to IDLE; int_i=1 -> poll next cycle.
